// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller.
package hazard_ctrl_pkg;

  // Width of the rd field held in each shadow entry.
  localparam int unsigned RD_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            ld;
    logic            mdu;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '0;

  // A source matches a stage only if it is read, the stage is live and the register is not x0.
  function automatic logic rd_match(input shadow_t e, input logic [RD_W-1:0] rs, input logic rs_use);
    return rs_use && e.v && (e.rd == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand forwarding select and load-hit detection against the shadow stages.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [RD_W-1:0] rs,
  input  logic            rs_use,
  input  shadow_t         ex,
  input  shadow_t         mem,
  input  shadow_t         wb,
  output fwd_sel_e        fwd,
  output logic            load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_bits;

  assign ex_hit  = rd_match(ex, rs, rs_use);
  assign mem_hit = rd_match(mem, rs, rs_use);
  assign wb_hit  = rd_match(wb, rs, rs_use);

  // Youngest producer wins; a load in EX has no result yet, so it falls through to older stages.
  always_comb begin
    fwd = FWD_RF;
    if (ex_hit && !ex.ld) begin
      fwd = FWD_EX;
    end else if (mem_hit) begin
      fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

  assign load_hit = ex_hit && ex.ld;

  // Entry fields not needed for matching.
  assign unused_bits = ^{ex.mdu, mem.ld, mem.mdu, wb.ld, wb.mdu};

endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage sequencing: issue/hold/bubble decisions, forwarding selects and MDU wait.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned TO_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid_i,
  input  logic [REG_W-1:0] dec_rs1_i,
  input  logic [REG_W-1:0] dec_rs2_i,
  input  logic             dec_rs1_use_i,
  input  logic             dec_rs2_use_i,
  input  logic [REG_W-1:0] dec_rd_i,
  input  logic             dec_load_i,
  input  logic             dec_mdu_i,
  input  logic             mdu_done_i,
  input  logic             redirect_i,
  output logic             stall_front_o,
  output logic             hold_ex_o,
  output logic             bubble_ex_o,
  output logic             flush_o,
  output logic [1:0]       fwd1_o,
  output logic [1:0]       fwd2_o,
  output logic             mdu_err_o
);

  state_e          state_q;
  shadow_t         ex_q;
  shadow_t         mem_q;
  shadow_t         wb_q;
  shadow_t         dec_entry;
  logic [TO_W-1:0] to_cnt_q;
  logic            mdu_err_q;

  fwd_sel_e        fwd1_sel;
  fwd_sel_e        fwd2_sel;
  logic            ld_hit1;
  logic            ld_hit2;
  logic            run_c;
  logic            load_use_c;
  logic            issue_c;

  hazard_match u_match_rs1 (
    .rs       (RD_W'(dec_rs1_i)),
    .rs_use   (dec_rs1_use_i),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .fwd      (fwd1_sel),
    .load_hit (ld_hit1)
  );

  hazard_match u_match_rs2 (
    .rs       (RD_W'(dec_rs2_i)),
    .rs_use   (dec_rs2_use_i),
    .ex       (ex_q),
    .mem      (mem_q),
    .wb       (wb_q),
    .fwd      (fwd2_sel),
    .load_hit (ld_hit2)
  );

  // The MDU done cycle behaves as a normal RUN cycle, so the pipe advances on that edge.
  always_comb begin
    run_c            = (state_q == ST_RUN) || mdu_done_i;
    load_use_c       = dec_valid_i && (ld_hit1 || ld_hit2);
    issue_c          = run_c && dec_valid_i && !load_use_c && !redirect_i;
    dec_entry        = SHADOW_BUBBLE;
    dec_entry.v      = 1'b1;
    dec_entry.rd     = RD_W'(dec_rd_i);
    dec_entry.ld     = dec_load_i;
    dec_entry.mdu    = dec_mdu_i;
  end

  // Control outputs are same-cycle decisions; all read zero while reset is held.
  always_comb begin
    stall_front_o = 1'b0;
    hold_ex_o     = 1'b0;
    bubble_ex_o   = 1'b0;
    flush_o       = 1'b0;
    fwd1_o        = 2'(FWD_RF);
    fwd2_o        = 2'(FWD_RF);
    if (!rst) begin
      flush_o       = run_c && redirect_i;
      bubble_ex_o   = run_c && (redirect_i || load_use_c);
      hold_ex_o     = !run_c;
      stall_front_o = !run_c || (!redirect_i && load_use_c);
      fwd1_o        = 2'(fwd1_sel);
      fwd2_o        = 2'(fwd2_sel);
    end
  end

  // State, shadow pipeline and MDU timeout tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      ex_q      <= SHADOW_BUBBLE;
      mem_q     <= SHADOW_BUBBLE;
      wb_q      <= SHADOW_BUBBLE;
      to_cnt_q  <= '0;
      mdu_err_q <= 1'b0;
    end else if (run_c) begin
      ex_q     <= issue_c ? dec_entry : SHADOW_BUBBLE;
      mem_q    <= ex_q;
      wb_q     <= mem_q;
      state_q  <= (issue_c && dec_mdu_i) ? ST_MDU_WAIT : ST_RUN;
      to_cnt_q <= '0;
    end else begin
      mem_q <= SHADOW_BUBBLE;
      wb_q  <= mem_q;
      if (to_cnt_q != TO_W'(MDU_TIMEOUT)) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      // Flag rises on the edge the counter reaches the limit; the FSM keeps waiting.
      if (to_cnt_q >= TO_W'(MDU_TIMEOUT - 1)) begin
        mdu_err_q <= 1'b1;
      end
    end
  end

  assign mdu_err_o = mdu_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations, a monitor checks them.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs1 = '0;
  logic [4:0] dec_rs2 = '0;
  logic       dec_rs1_use = 1'b0;
  logic       dec_rs2_use = 1'b0;
  logic [4:0] dec_rd = '0;
  logic       dec_load = 1'b0;
  logic       dec_mdu = 1'b0;
  logic       mdu_done = 1'b0;
  logic       redirect = 1'b0;

  logic       stall_a, hold_a, bubble_a, flush_a, err_a;
  logic [1:0] fwd1_a, fwd2_a;
  logic       stall_b, hold_b, bubble_b, flush_b, err_b;
  logic [1:0] fwd1_b, fwd2_b;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_use_i(dec_rs1_use), .dec_rs2_use_i(dec_rs2_use), .dec_rd_i(dec_rd),
    .dec_load_i(dec_load), .dec_mdu_i(dec_mdu), .mdu_done_i(mdu_done), .redirect_i(redirect),
    .stall_front_o(stall_a), .hold_ex_o(hold_a), .bubble_ex_o(bubble_a), .flush_o(flush_a),
    .fwd1_o(fwd1_a), .fwd2_o(fwd2_a), .mdu_err_o(err_a)
  );

  hazard_ctrl #(.REG_W(5), .MDU_TIMEOUT(4), .TO_W(3)) u_dut_to (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid), .dec_rs1_i(dec_rs1), .dec_rs2_i(dec_rs2),
    .dec_rs1_use_i(dec_rs1_use), .dec_rs2_use_i(dec_rs2_use), .dec_rd_i(dec_rd),
    .dec_load_i(dec_load), .dec_mdu_i(dec_mdu), .mdu_done_i(mdu_done), .redirect_i(redirect),
    .stall_front_o(stall_b), .hold_ex_o(hold_b), .bubble_ex_o(bubble_b), .flush_o(flush_b),
    .fwd1_o(fwd1_b), .fwd2_o(fwd2_b), .mdu_err_o(err_b)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       mdu;
    logic       done;
    logic       redir;
  } stim_t;

  // err: default-timeout instance; err4: instance with MDU_TIMEOUT=4.
  typedef struct packed {
    logic       stall;
    logic       hold;
    logic       bubble;
    logic       flush;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       err;
    logic       err4;
  } exp_t;

  typedef struct {
    string name;
    exp_t  e;
  } sb_t;

  sb_t        sb_q[$];
  sb_t        mon_r;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] got_v;
  logic [8:0] exp_v;

  function automatic stim_t op(input int rs1, input bit u1, input int rs2, input bit u2,
                               input int rd, input bit ld = 1'b0, input bit mdu = 1'b0);
    stim_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rs1   = 5'(rs1);
    s.u1    = u1;
    s.rs2   = 5'(rs2);
    s.u2    = u2;
    s.rd    = 5'(rd);
    s.ld    = ld;
    s.mdu   = mdu;
    return s;
  endfunction

  function automatic stim_t ctl(input stim_t s, input bit rst_v, input bit done_v, input bit redir_v);
    stim_t r;
    r       = s;
    r.rst   = rst_v;
    r.done  = done_v;
    r.redir = redir_v;
    return r;
  endfunction

  function automatic exp_t ex(input bit stall, input bit hold, input bit bubble, input bit flush,
                              input int f1, input int f2, input bit err, input bit err4);
    exp_t e;
    e.stall  = stall;
    e.hold   = hold;
    e.bubble = bubble;
    e.flush  = flush;
    e.f1     = 2'(f1);
    e.f2     = 2'(f2);
    e.err    = err;
    e.err4   = err4;
    return e;
  endfunction

  task automatic step(input string name, input stim_t s, input exp_t e);
    sb_t r;
    @(posedge clk);
    #1;
    rst         = s.rst;
    dec_valid   = s.valid;
    dec_rs1     = s.rs1;
    dec_rs1_use = s.u1;
    dec_rs2     = s.rs2;
    dec_rs2_use = s.u2;
    dec_rd      = s.rd;
    dec_load    = s.ld;
    dec_mdu     = s.mdu;
    mdu_done    = s.done;
    redirect    = s.redir;
    r.name      = name;
    r.e         = e;
    sb_q.push_back(r);
  endtask

  // Monitor: outputs are stable mid-cycle, so each expectation is checked on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_r = sb_q.pop_front();
      got_v = {stall_a, hold_a, bubble_a, flush_a, fwd1_a, fwd2_a, err_a};
      exp_v = {mon_r.e.stall, mon_r.e.hold, mon_r.e.bubble, mon_r.e.flush,
               mon_r.e.f1, mon_r.e.f2, mon_r.e.err};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s dut=default {stall,hold,bubble,flush,f1,f2,err} got=%b exp=%b",
                 mon_r.name, got_v, exp_v);
      end
      got_v = {stall_b, hold_b, bubble_b, flush_b, fwd1_b, fwd2_b, err_b};
      exp_v = {mon_r.e.stall, mon_r.e.hold, mon_r.e.bubble, mon_r.e.flush,
               mon_r.e.f1, mon_r.e.f2, mon_r.e.err4};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s dut=timeout4 {stall,hold,bubble,flush,f1,f2,err} got=%b exp=%b",
                 mon_r.name, got_v, exp_v);
      end
    end
  end

  initial begin
    stim_t idle;
    stim_t wait_op;
    idle = '0;

    // Reset holds every output low regardless of inputs.
    step("reset", ctl(op(5, 1, 6, 1, 5, 1'b1, 1'b1), 1'b1, 1'b0, 1'b1), ex(0,0,0,0, 0,0, 0,0));

    // Forwarding distance: EX, MEM, WB.
    step("add_x5",     op(1, 1, 2, 1, 5),           ex(0,0,0,0, 0,0, 0,0));
    step("fwd_ex",     op(5, 1, 1, 1, 6),           ex(0,0,0,0, 1,0, 0,0));
    step("fwd_mem",    op(5, 1, 0, 0, 10),          ex(0,0,0,0, 2,0, 0,0));
    step("fwd_wb_mem", op(5, 1, 6, 1, 11),          ex(0,0,0,0, 3,2, 0,0));
    step("wr_x6",      op(0, 0, 0, 0, 6),           ex(0,0,0,0, 0,0, 0,0));
    step("wr_x6_b",    op(11, 1, 0, 0, 6),          ex(0,0,0,0, 2,0, 0,0));
    // Youngest producer wins; this op is a load writing x0.
    step("youngest",   op(6, 1, 11, 1, 0, 1'b1),    ex(0,0,0,0, 1,3, 0,0));
    // x0 is never forwarded or stalled on, even behind a load to x0.
    step("x0_read",    op(0, 1, 0, 1, 12),          ex(0,0,0,0, 0,0, 0,0));
    // Unused rs1 does not forward; lw x7.
    step("lw_x7",      op(12, 0, 6, 1, 7, 1'b1),    ex(0,0,0,0, 0,3, 0,0));
    // Load-use: one stall+bubble cycle, then MEM forwarding.
    step("load_use",   op(7, 1, 7, 1, 8),           ex(1,0,1,0, 0,0, 0,0));
    step("after_lu",   op(7, 1, 7, 1, 8),           ex(0,0,0,0, 2,2, 0,0));
    step("lw_x9",      op(0, 0, 0, 0, 9, 1'b1),     ex(0,0,0,0, 0,0, 0,0));
    // Redirect beats a load-use hazard.
    step("redir_lu",   ctl(op(9, 1, 8, 1, 13), 1'b0, 1'b0, 1'b1), ex(0,0,1,1, 0,2, 0,0));
    step("idle",       idle,                        ex(0,0,0,0, 0,0, 0,0));

    // MDU op, done after five wait cycles.
    step("mdu_issue",  op(9, 1, 0, 0, 14, 1'b0, 1'b1), ex(0,0,0,0, 3,0, 0,0));
    wait_op = op(14, 1, 0, 1, 15);
    step("mdu_w1",     wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("mdu_w2",     wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("mdu_w3_redir", ctl(wait_op, 1'b0, 1'b0, 1'b1), ex(1,1,0,0, 1,0, 0,0));
    step("mdu_w4",     wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("mdu_w5",     wait_op,                     ex(1,1,0,0, 1,0, 0,1));
    step("mdu_done",   ctl(wait_op, 1'b0, 1'b1, 1'b0), ex(0,0,0,0, 1,0, 0,1));
    step("done_in_run", ctl(idle, 1'b0, 1'b1, 1'b0), ex(0,0,0,0, 0,0, 0,1));
    step("run_after",  op(15, 1, 14, 1, 16),        ex(0,0,0,0, 2,3, 0,1));

    // Timeout: sticky error while the FSM keeps waiting, then reset mid-wait.
    step("rst_clear",  ctl(idle, 1'b1, 1'b0, 1'b0), ex(0,0,0,0, 0,0, 0,0));
    step("to_issue",   op(0, 0, 0, 0, 20, 1'b0, 1'b1), ex(0,0,0,0, 0,0, 0,0));
    wait_op = op(20, 1, 0, 0, 21);
    step("to_w1",      wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("to_w2",      wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("to_w3",      wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("to_w4",      wait_op,                     ex(1,1,0,0, 1,0, 0,0));
    step("to_w5",      wait_op,                     ex(1,1,0,0, 1,0, 0,1));
    step("to_w6_redir", ctl(wait_op, 1'b0, 1'b0, 1'b1), ex(1,1,0,0, 1,0, 0,1));
    step("to_w7",      wait_op,                     ex(1,1,0,0, 1,0, 0,1));
    step("rst_mid",    ctl(wait_op, 1'b1, 1'b0, 1'b0), ex(0,0,0,0, 0,0, 0,0));
    step("post_rst",   wait_op,                     ex(0,0,0,0, 0,0, 0,0));

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the execute stage. It decides each cycle whether the decoded instruction issues into the dec-to-ex pipeline register, is held, or is replaced by a bubble.
- It keeps a shadow scoreboard of destination registers in flight in EX, MEM and WB. From that it produces operand-forwarding selects, load-use stalls, multi-cycle (MDU) holds and branch-redirect flushes.
- Sits beside decode. It drives the `stall` input of the ALU stage and the front-end freeze.

Parameters:
- REG_W, 5, architectural register index width
- MDU_TIMEOUT, 64, max cycles in MDU_WAIT before the error flag is raised
- TO_W, 7, width of the timeout counter; must be at least clog2(MDU_TIMEOUT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rs1_i  in  REG_W  source register 1 index
- dec_rs2_i  in  REG_W  source register 2 index
- dec_rs1_use_i  in  1  rs1 is read
- dec_rs2_use_i  in  1  rs2 is read
- dec_rd_i  in  REG_W  destination register (0 = none)
- dec_load_i  in  1  instruction is a load
- dec_mdu_i  in  1  instruction is a multi-cycle MDU op
- mdu_done_i  in  1  MDU result valid this cycle
- redirect_i  in  1  EX resolved a taken branch/jump
- stall_front_o  out  1  freeze IF and decode
- hold_ex_o  out  1  dec-to-ex register keeps its contents
- bubble_ex_o  out  1  dec-to-ex register loads instValid=0, aluOp=ALU_NOP
- flush_o  out  1  squash the IF/decode instructions
- fwd1_o  out  2  rs1 source select
- fwd2_o  out  2  rs2 source select
- mdu_err_o  out  1  sticky MDU timeout error

Behaviour:
- Reset (asynchronous): state=RUN; all shadow valid bits=0; timeout counter=0; mdu_err_o=0. Every output reads 0 while reset is held.
- Shadow entries: EX, MEM and WB each store {v, rd, ld, mdu}.
- Shadow advance on each clk edge while state=RUN:
  - EX <= decode fields if an issue occurs, else a bubble (v=0).
  - MEM <= EX, WB <= MEM.
- An issue occurs when dec_valid_i=1, there is no load-use hazard and redirect_i=0.
- In MDU_WAIT: EX is held; MEM <= bubble; WB <= MEM.
- Match rule: rsN matches stage S when rsN_use=1, S.v=1, S.rd==rsN and rsN!=0. Register x0 is never forwarded or stalled on.
- Forwarding (combinational), youngest producer wins:
  - 1 = EX result, when EX matches and EX.ld=0
  - else 2 = MEM result
  - else 3 = WB result
  - else 0 = register file
- Load-use hazard: EX matches rs1 or rs2 with EX.ld=1. Response: stall_front_o=1, bubble_ex_o=1 for exactly 1 cycle. Next cycle the load is in MEM and forwarding selects 2.
- FSM RUN -> MDU_WAIT: on the edge where an instruction with dec_mdu_i=1 issues into EX.
- In MDU_WAIT:
  - stall_front_o=1 and hold_ex_o=1.
  - Timeout counter increments each cycle and saturates.
  - redirect_i is ignored (EX holds the MDU op).
- MDU_WAIT -> RUN: in the cycle mdu_done_i=1, stall_front_o=0 and hold_ex_o=0. Normal advance happens at that edge and the counter clears.
- mdu_done_i in RUN is ignored.
- Timeout: when the counter reaches MDU_TIMEOUT, mdu_err_o sets and stays set until reset. The FSM keeps waiting.
- Redirect (RUN only): flush_o=1 and bubble_ex_o=1 the same cycle. Redirect overrides a load-use stall in that cycle (stall_front_o=0). No issue occurs.
- Output priority in RUN: redirect > load-use > issue.
- Reset mid-MDU: returns to RUN immediately and the shadows clear. The MDU unit is reset separately.

Decomposition:
- Shared package gets:
  - fwd-select enum FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3
  - FSM enum ST_RUN, ST_MDU_WAIT
  - shadow-entry struct {v, rd, ld, mdu}
- One natural sub-module: hazard_match. It is combinational and instantiated twice, once for rs1 and once for rs2. Inputs: one rs index, its use bit and the three shadow entries. Outputs: the fwd select and a load-hit flag.

Test Plan:
- Back-to-back dependency: add x5 then add x6,x5,x1 → second op sees fwd1_o=1, no stall. One op between → fwd1_o=2. Two ops between → fwd1_o=3.
- Load-use: lw x7 then add x8,x7,x7 → 1 cycle with stall_front_o=1, bubble_ex_o=1. Next cycle fwd1_o=fwd2_o=2.
- x0 writer: op with rd=0, then a reader of x0 → fwd=0, no stall.
- MDU op with mdu_done_i after 5 cycles → hold_ex_o=stall_front_o=1 for 5 cycles. Both drop in the done cycle; mdu_err_o stays 0.
- MDU_TIMEOUT=4, no done → mdu_err_o rises on cycle 4 and stays 1. Asserting rst mid-wait → state RUN, all outputs 0.
- redirect_i together with a load-use hazard → flush_o=1, bubble_ex_o=1, stall_front_o=0. redirect_i during MDU_WAIT → flush_o stays 0.
